// File: rtl/mq_out_slot_pkg.sv
// Shared types and width helpers for the outgoing message-queue slot.
package mq_pkg;

  localparam int c_mq_word_width = 32;

  typedef enum logic {
    IDLE    = 1'b0,
    CLAIMED = 1'b1
  } t_mq_prod_state;

  // Entry-index width; a 1-entry queue still needs one index bit for the pointer.
  function automatic int f_entry_aw(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

  function automatic int f_word_aw(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/mq_out_slot_if.sv
// Producer (CPU) and consumer (host register map) signals of the message slot.
interface mq_out_slot_if #(
  parameter int G_ENTRIES = 4,
  parameter int G_WORDS   = 128
);
  localparam int WAW = mq_pkg::f_word_aw(G_WORDS);
  localparam int SW  = WAW + 1;
  localparam int CW  = mq_pkg::f_entry_aw(G_ENTRIES) + 1;
  localparam int DW  = mq_pkg::c_mq_word_width;

  logic           claim_i;
  logic           claim_ok_o;
  logic           claim_err_o;
  logic [WAW-1:0] wr_addr_i;
  logic [DW-1:0]  wr_data_i;
  logic           wr_en_i;
  logic           commit_i;
  logic [SW-1:0]  commit_size_i;
  logic           purge_i;
  logic [WAW-1:0] rd_addr_i;
  logic [DW-1:0]  rd_data_o;
  logic [SW-1:0]  rd_size_o;
  logic           discard_i;
  logic [CW-1:0]  count_o;
  logic           full_o;
  logic           empty_o;
  logic           claimed_o;
  logic           irq_o;

  modport master (
    output claim_i, wr_addr_i, wr_data_i, wr_en_i, commit_i, commit_size_i,
           purge_i, rd_addr_i, discard_i,
    input  claim_ok_o, claim_err_o, rd_data_o, rd_size_o, count_o,
           full_o, empty_o, claimed_o, irq_o
  );

  modport slave (
    input  claim_i, wr_addr_i, wr_data_i, wr_en_i, commit_i, commit_size_i,
           purge_i, rd_addr_i, discard_i,
    output claim_ok_o, claim_err_o, rd_data_o, rd_size_o, count_o,
           full_o, empty_o, claimed_o, irq_o
  );

endinterface

// File: rtl/mq_out_slot_ram.sv
// Simple dual-port RAM: one write port, one registered read port (read-before-write).
module mq_slot_ram #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Only the output register is reset; the array keeps stale contents.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) rdata_q <= '0;
    else          rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mq_out_slot.sv
// Outgoing message-queue slot: claim/fill/commit on the CPU side, read/discard on the host side.
module mq_out_slot
  import mq_pkg::*;
#(
  parameter int G_ENTRIES = 4,
  parameter int G_WORDS   = 128
) (
  input logic          clk_sys_i,
  input logic          rst_n_i,
  mq_out_slot_if.slave bus
);

  localparam int EW = f_entry_aw(G_ENTRIES);
  localparam int WAW = f_word_aw(G_WORDS);
  localparam int PW = EW + 1;
  localparam int SW = WAW + 1;

  t_mq_prod_state state_q;
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [SW-1:0]  size_q [G_ENTRIES];
  logic           claim_ok_q, claim_err_q;

  logic           full, empty, commit_go, discard_go, ram_we;
  logic [SW-1:0]  size_clamped;

  // Wrap bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[EW-1:0] == rd_ptr_q[EW-1:0]) && (wr_ptr_q[EW] != rd_ptr_q[EW]);

  assign commit_go    = (state_q == CLAIMED) && bus.commit_i;
  assign discard_go   = !empty && bus.discard_i;
  assign ram_we       = (state_q == CLAIMED) && bus.wr_en_i && !bus.purge_i;
  assign size_clamped = (bus.commit_size_i > SW'(G_WORDS)) ? SW'(G_WORDS) : bus.commit_size_i;

  always_ff @(posedge clk_sys_i) begin
    if (!rst_n_i || bus.purge_i) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      claim_ok_q  <= 1'b0;
      claim_err_q <= 1'b0;
    end else begin
      claim_ok_q  <= 1'b0;
      claim_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.claim_i) begin
            if (full) begin
              claim_err_q <= 1'b1;
            end else begin
              claim_ok_q <= 1'b1;
              state_q    <= CLAIMED;
            end
          end
        end
        CLAIMED: begin
          if (bus.commit_i) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (discard_go) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_n_i && !bus.purge_i && commit_go) size_q[wr_ptr_q[EW-1:0]] <= size_clamped;
  end

  mq_slot_ram #(
    .AW(EW + WAW),
    .DW(c_mq_word_width)
  ) u_ram (
    .clk_i   (clk_sys_i),
    .rst_n_i (rst_n_i),
    .we_i    (ram_we),
    .waddr_i ({wr_ptr_q[EW-1:0], bus.wr_addr_i}),
    .wdata_i (bus.wr_data_i),
    .raddr_i ({rd_ptr_q[EW-1:0], bus.rd_addr_i}),
    .rdata_o (bus.rd_data_o)
  );

  assign bus.claim_ok_o  = claim_ok_q;
  assign bus.claim_err_o = claim_err_q;
  assign bus.claimed_o   = (state_q == CLAIMED);
  assign bus.count_o     = wr_ptr_q - rd_ptr_q;
  assign bus.empty_o     = empty;
  assign bus.full_o      = full;
  assign bus.irq_o       = !empty;
  assign bus.rd_size_o   = empty ? '0 : size_q[rd_ptr_q[EW-1:0]];

endmodule

// File: tb/tb_mq_out_slot.sv
// Scoreboard bench for mq_out_slot: message-level queue model, expectations checked by a monitor.
module tb_mq_out_slot;

  localparam int E = 4;
  localparam int W = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mq_out_slot_if #(.G_ENTRIES(E), .G_WORDS(W)) bus();

  mq_out_slot #(.G_ENTRIES(E), .G_WORDS(W)) dut (
    .clk_sys_i (clk),
    .rst_n_i   (rst_n),
    .bus       (bus)
  );

  typedef struct {
    int          cnt;
    bit          emp, ful, irq, clm, ok, err;
    int          rsz;
    bit          chkd;
    logic [31:0] dat;
  } exp_t;

  exp_t expq[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: committed messages as ids + sizes, written words keyed by (id, word).
  int          m_id[$];
  int          m_sz[$];
  logic [31:0] wmem [longint];
  bit          claimed = 0;
  int          cur_id = 0;
  int          next_id = 1;

  function automatic longint key(input int id, input int wa);
    return longint'(id) * 1024 + wa;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    exp_t e;
    int   pre_n;
    bit   ok, err;
    int   sz;
    pre_n  = m_id.size();
    e.chkd = 0;
    e.dat  = '0;
    ok     = 0;
    err    = 0;
    if (!rst_n) begin
      e.chkd = 1;
    end else if (pre_n > 0 && wmem.exists(key(m_id[0], int'(bus.rd_addr_i)))) begin
      e.chkd = 1;
      e.dat  = wmem[key(m_id[0], int'(bus.rd_addr_i))];
    end
    if (!rst_n || bus.purge_i) begin
      m_id.delete();
      m_sz.delete();
      claimed = 0;
    end else begin
      ok  = bus.claim_i && !claimed && (pre_n < E);
      err = bus.claim_i && !claimed && (pre_n == E);
      if (claimed && bus.wr_en_i) wmem[key(cur_id, int'(bus.wr_addr_i))] = bus.wr_data_i;
      if (bus.discard_i && pre_n > 0) begin
        void'(m_id.pop_front());
        void'(m_sz.pop_front());
      end
      if (claimed && bus.commit_i) begin
        sz = int'(bus.commit_size_i);
        if (sz > W) sz = W;
        m_id.push_back(cur_id);
        m_sz.push_back(sz);
        claimed = 0;
      end
      if (ok) begin
        claimed = 1;
        cur_id  = next_id++;
      end
    end
    e.cnt = m_id.size();
    e.emp = (m_id.size() == 0);
    e.ful = (m_id.size() == E);
    e.irq = !e.emp;
    e.clm = claimed;
    e.ok  = ok;
    e.err = err;
    e.rsz = e.emp ? 0 : m_sz[0];
    expq.push_back(e);
    @(posedge clk);
    #1;
    bus.claim_i   = 0;
    bus.wr_en_i   = 0;
    bus.commit_i  = 0;
    bus.purge_i   = 0;
    bus.discard_i = 0;
  endtask

  task automatic do_claim();
    bus.claim_i = 1;
    tick();
  endtask

  task automatic do_write(input int a, input logic [31:0] d);
    bus.wr_en_i   = 1;
    bus.wr_addr_i = 7'(a);
    bus.wr_data_i = d;
    tick();
  endtask

  task automatic do_commit(input int sz);
    bus.commit_i      = 1;
    bus.commit_size_i = 8'(sz);
    tick();
  endtask

  task automatic do_read(input int a);
    bus.rd_addr_i = 7'(a);
    tick();
  endtask

  task automatic do_discard();
    bus.discard_i = 1;
    tick();
  endtask

  task automatic one_msg(input int sz, input logic [31:0] w0);
    do_claim();
    do_write(0, w0);
    do_commit(sz);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("count_o", bus.count_o, e.cnt);
      chk("empty_o", bus.empty_o, e.emp);
      chk("full_o", bus.full_o, e.ful);
      chk("irq_o", bus.irq_o, e.irq);
      chk("claimed_o", bus.claimed_o, e.clm);
      chk("claim_ok_o", bus.claim_ok_o, e.ok);
      chk("claim_err_o", bus.claim_err_o, e.err);
      chk("rd_size_o", bus.rd_size_o, e.rsz);
      if (e.chkd) chk("rd_data_o", bus.rd_data_o, e.dat);
    end
  end

  initial begin
    bus.claim_i       = 0;
    bus.wr_addr_i     = '0;
    bus.wr_data_i     = '0;
    bus.wr_en_i       = 0;
    bus.commit_i      = 0;
    bus.commit_size_i = '0;
    bus.purge_i       = 0;
    bus.rd_addr_i     = '0;
    bus.discard_i     = 0;

    rst_n = 0;
    tick();
    rst_n = 1;
    tick();

    // Single message
    do_claim();
    for (int i = 0; i < 3; i++) do_write(i, 32'(i + 1));
    do_commit(3);
    for (int i = 0; i < 3; i++) do_read(i);
    tick();
    do_discard();
    tick();

    // Fill, refuse, then recover one slot
    for (int i = 0; i < E; i++) one_msg(i + 1, 32'h100 + 32'(i));
    do_claim();
    do_discard();
    do_claim();
    do_commit(9);
    for (int i = 0; i < E; i++) begin
      do_read(0);
      do_discard();
    end
    tick();

    // Wrap-around: sizes 1..10 through the ring
    for (int k = 1; k <= 10; k++) begin
      one_msg(k, 32'hA000 + 32'(k));
      do_read(0);
      do_discard();
    end

    // Commit and discard together with two queued
    one_msg(5, 32'hB1);
    one_msg(6, 32'hB2);
    do_claim();
    do_write(0, 32'hB3);
    bus.commit_i      = 1;
    bus.commit_size_i = 8'd7;
    bus.discard_i     = 1;
    tick();
    do_read(0);
    tick();
    for (int i = 0; i < 2; i++) do_discard();
    tick();

    // Purge mid-claim, then a stray commit
    one_msg(2, 32'hC0);
    do_claim();
    for (int i = 0; i < 5; i++) do_write(i, 32'hD0 + 32'(i));
    bus.purge_i = 1;
    tick();
    do_commit(4);
    tick();

    // Reset with three queued, then clamp an oversize commit
    for (int i = 0; i < 3; i++) one_msg(i + 2, 32'hE0 + 32'(i));
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
    do_claim();
    do_write(1, 32'hF1);
    do_commit(200);
    do_read(1);
    do_discard();
    tick();

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      bus.claim_i       = ($urandom_range(99) < 25);
      bus.wr_en_i       = ($urandom_range(99) < 50);
      bus.wr_addr_i     = 7'($urandom_range(7));
      bus.wr_data_i     = $urandom;
      bus.commit_i      = ($urandom_range(99) < 20);
      bus.commit_size_i = 8'($urandom_range(255));
      bus.discard_i     = ($urandom_range(99) < 15);
      bus.purge_i       = ($urandom_range(99) < 2);
      bus.rd_addr_i     = 7'($urandom_range(7));
      rst_n             = ($urandom_range(199) != 0);
      tick();
    end
    rst_n = 1;
    tick();

    for (int i = 0; i < 5 && expq.size() > 0; i++) @(negedge clk);
    #1;
    if (expq.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mq_out_slot.md
# mq_out_slot

Outgoing message-queue slot between the node CPU (producer) and the host VME/Wishbone register map (consumer) of the host message queue. The CPU claims a free entry, fills it with 32-bit words, and commits it with a size. The host sees a non-empty status and reads the head entry word by word, then discards it. The host-side polling loop drives the consumer port through the bus slave; a CPU or firmware stub drives the producer port.

## Interface
Parameters:
- G_ENTRIES, 4: messages held; power of 2, 2..16.
- G_WORDS, 128: 32-bit words per message; power of 2.

Ports:
- clk_sys_i  in  1  system clock; the single clock of the block.
- rst_n_i  in  1  reset, synchronous, active-low.
- claim_i  in  1  producer request for a free entry (pulse).
- claim_ok_o  out  1  1-cycle pulse: claim granted.
- claim_err_o  out  1  1-cycle pulse: claim refused (full).
- wr_addr_i  in  clog2(G_WORDS)  word index inside the claimed entry.
- wr_data_i  in  32  producer write data.
- wr_en_i  in  1  producer write strobe.
- commit_i  in  1  publish the claimed entry (pulse).
- commit_size_i  in  clog2(G_WORDS)+1  number of valid words in the committed message.
- purge_i  in  1  flush all entries and cancel any claim.
- rd_addr_i  in  clog2(G_WORDS)  word index inside the head entry.
- rd_data_o  out  32  head entry word.
- rd_size_o  out  clog2(G_WORDS)+1  size of the head message; 0 when empty.
- discard_i  in  1  consumer pop of the head entry (pulse).
- count_o  out  clog2(G_ENTRIES)+1  committed entries.
- full_o / empty_o  out  1 each  count==G_ENTRIES / count==0.
- claimed_o  out  1  producer FSM in CLAIMED.
- irq_o  out  1  level, equals !empty_o.

## Operation
- Reset values:
  - Pointers, count, and all pulses are 0.
  - empty_o=1, full_o=0, claimed_o=0, irq_o=0.
  - rd_size_o=0 and rd_data_o=0.
- Storage: G_ENTRIES×G_WORDS words, plus one size register per entry.
- Pointers wr_ptr and rd_ptr are clog2(G_ENTRIES)+1 bits wide, with the MSB used as the wrap bit:
  - full: indices are equal and the MSBs differ.
  - empty: the pointers are equal.
- Producer FSM, states IDLE and CLAIMED:
  - IDLE, claim_i, not full: go to CLAIMED and pulse claim_ok_o.
  - IDLE, claim_i, full: stay in IDLE and pulse claim_err_o.
  - CLAIMED, claim_i: ignored, no pulse.
  - CLAIMED, wr_en_i: writes mem[wr_ptr][wr_addr_i].
  - IDLE, wr_en_i: ignored.
  - CLAIMED, commit_i: latches size[wr_ptr], increments wr_ptr (wrapping modulo 2·G_ENTRIES), returns to IDLE.
  - IDLE, commit_i: ignored.
- commit_size_i values above G_WORDS are clamped to G_WORDS.
- Consumer:
  - rd_data_o is the registered read of mem[rd_ptr][rd_addr_i].
  - rd_size_o shows size[rd_ptr] while non-empty.
  - discard_i when non-empty increments rd_ptr.
  - discard_i when empty is ignored.
- Commit and discard in the same cycle: both are applied and count is unchanged.
- Claim while full in the same cycle as a discard: refused. Full is evaluated on the registered state.
- purge_i has priority over everything:
  - Both pointers are set to 0 and the FSM goes to IDLE.
  - No pulses are generated in that cycle.
  - Memory contents are not cleared.
- Any reset, or a purge while CLAIMED, drops the partial message silently.

## Timing
- claim_i at cycle N: claim_ok_o or claim_err_o high at N+1 only; claimed_o high from N+1.
- Producer writes are accepted from N+1.
- commit_i at N: count_o, empty_o, full_o, irq_o and rd_size_o updated at N+1; claimed_o low at N+1.
- rd_addr_i at N: rd_data_o valid at N+1, a 1-cycle latency with no stall.
- discard_i at N: pointer and count updated at N+1. The new head word requested at N+1 is valid at N+2.
- A write and a read of the same word in the same cycle return old data. This cannot occur by construction, because the claimed entry is never the head entry unless the queue is empty.

## Structure
- Package mq_pkg:
  - Typedef t_mq_prod_state (IDLE, CLAIMED).
  - Functions computing the address widths from G_ENTRIES and G_WORDS.
  - Constant c_mq_word_width = 32.
- Sub-module mq_slot_ram: simple dual-port synchronous RAM, one write port and one registered read port. The entry index and word index are concatenated to form the address.
- Top level: FSM, pointers, size registers, status logic.

## Test plan
- Single message:
  - Stimulus: claim; write words 0..2 = 1,2,3; commit size 3.
  - Required: claim_ok_o pulse at N+1; then empty_o=0, irq_o=1, rd_size_o=3.
  - Reading addresses 0..2 returns 1,2,3; after discard, empty_o=1.
- Fill to G_ENTRIES=4:
  - Stimulus: commit 4 messages, then claim.
  - Required: full_o=1 and claim_err_o pulses.
  - After one discard, a claim yields claim_ok_o and count_o=3.
- Wrap-around:
  - Stimulus: 10 claim/commit/discard cycles carrying the sizes 1..10.
  - Required: each head reads back the correct size and first word; the pointer MSB toggles every 4 messages.
- Simultaneous commit and discard with count=2:
  - Required: count_o stays 2; the head advances to the next message.
- Purge mid-claim:
  - Stimulus: purge after claiming and writing 5 words.
  - Required: claimed_o=0, count_o=0, empty_o=1, no pulses.
  - A following commit_i is ignored.
- Reset and clamping:
  - Stimulus: assert rst_n_i low for 1 cycle with 3 entries queued.
  - Required: all outputs return to their reset values at the next edge.
  - A subsequent commit with size 200 (G_WORDS=128) gives rd_size_o=128.
